// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with combinational reads, optional write bypass and zero register,
// plus a clear sequencer that sweeps one entry per cycle and pulses clr_done when finished.
module regfile_2r1w #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [DATA_W-1:0] rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);
   localparam int NREG = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] mem [NREG];
   logic              wr_ok;
   logic              byp0;
   logic              byp1;

   // DONE accepts writes again; only the sweep itself blocks the write port.
   assign wr_ok = we && (state != CLEAR) && !(ZERO_REG && (waddr == '0));
   assign byp0  = BYPASS && wr_ok && (waddr == raddr0);
   assign byp1  = BYPASS && wr_ok && (waddr == raddr1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
         state    <= IDLE;
         cnt      <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         clr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_ok) begin
                  mem[waddr] <= wdata;
               end
               if (clr_req) begin
                  state    <= CLEAR;
                  cnt      <= '0;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               mem[cnt] <= '0;
               if (cnt == ADDR_W'(NREG - 1)) begin
                  state    <= DONE;
                  clr_busy <= 1'b0;
                  clr_done <= 1'b1;
               end else begin
                  cnt <= cnt + ADDR_W'(1);
               end
            end
            DONE: begin
               if (wr_ok) begin
                  mem[waddr] <= wdata;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      rdata0 = mem[raddr0];
      if (byp0) begin
         rdata0 = wdata;
      end
      if (!rst_n || (ZERO_REG && (raddr0 == '0))) begin
         rdata0 = '0;
      end
   end

   always_comb begin
      rdata1 = mem[raddr1];
      if (byp1) begin
         rdata1 = wdata;
      end
      if (!rst_n || (ZERO_REG && (raddr1 == '0))) begin
         rdata1 = '0;
      end
   end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: default 32x32 build checked every cycle against an array model,
// plus a small 8x16 build without zero register or bypass checked with directed values.
module tb_regfile_2r1w;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NREG = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          we = 1'b0;
   logic          clr_req = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [AW-1:0] raddr0 = '0;
   logic [AW-1:0] raddr1 = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata0;
   logic [DW-1:0] rdata1;
   logic          clr_busy;
   logic          clr_done;

   logic          s_we = 1'b0;
   logic          s_clr_req = 1'b0;
   logic [2:0]    s_waddr = '0;
   logic [2:0]    s_raddr0 = '0;
   logic [2:0]    s_raddr1 = '0;
   logic [15:0]   s_wdata = '0;
   logic [15:0]   s_rdata0;
   logic [15:0]   s_rdata1;
   logic          s_busy;
   logic          s_done;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_2r1w dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_s (
      .clk(clk), .rst_n(rst_n), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
      .raddr0(s_raddr0), .rdata0(s_rdata0), .raddr1(s_raddr1), .rdata1(s_rdata1),
      .clr_req(s_clr_req), .clr_busy(s_busy), .clr_done(s_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: contents array, sweep position (-1 when no sweep running), done flag.
   logic [DW-1:0] m_mem [NREG];
   int            m_sweep = -1;
   bit            m_done = 1'b0;
   bit            chk_en = 1'b0;

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
      m_sweep = -1;
      m_done  = 1'b0;
   endtask

   function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (we && (m_sweep < 0) && (waddr == a)) return wdata;
      return m_mem[a];
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         if (m_sweep >= 0) begin
            m_mem[m_sweep] = '0;
            m_sweep++;
            m_done = (m_sweep == NREG);
            if (m_done) m_sweep = -1;
         end else begin
            if (we && (waddr != '0)) m_mem[waddr] = wdata;
            if (clr_req && !m_done) m_sweep = 0;
            m_done = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("rdata0", rdata0, m_read(raddr0));
         check("rdata1", rdata1, m_read(raddr1));
         check("clr_busy", clr_busy, m_sweep >= 0);
         check("clr_done", clr_done, m_done);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int busy_cnt, done_cnt, done_at;

   initial begin
      model_reset();
      // Reset: every address reads zero on both ports, even with a write pending.
      step();
      for (int i = 0; i < NREG; i++) begin
         raddr0 = AW'(i); raddr1 = AW'(NREG - 1 - i);
         we = 1'b1; waddr = AW'(i); wdata = $urandom;
         #1;
         check("reset_rdata0", rdata0, 32'h0);
         check("reset_rdata1", rdata1, 32'h0);
      end
      we = 1'b0;
      check("reset_busy", clr_busy, 1'b0);
      check("reset_done", clr_done, 1'b0);
      step();
      rst_n = 1'b1;
      chk_en = 1'b1;
      step();

      // Small build: write/readback 8 entries, no bypass, 8-cycle clear.
      for (int i = 0; i < 8; i++) begin
         s_we = 1'b1; s_waddr = 3'(i); s_wdata = 16'(32'hA500 + i);
         step();
      end
      s_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_raddr0 = 3'(i); s_raddr1 = 3'(7 - i);
         #1;
         check("s_read0", s_rdata0, 32'hA500 + i);
         check("s_read1", s_rdata1, 32'hA507 - i);
      end
      s_we = 1'b1; s_waddr = 3'd3; s_wdata = 16'hBEEF; s_raddr0 = 3'd3; s_raddr1 = 3'd3;
      #1;
      check("s_nobyp0", s_rdata0, 16'hA503);
      check("s_nobyp1", s_rdata1, 16'hA503);
      step();
      s_we = 1'b0;
      check("s_after_wr", s_rdata0, 16'hBEEF);
      s_clr_req = 1'b1;
      step();
      s_clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 14; c++) begin
         if (s_busy) busy_cnt++;
         if (s_done) begin done_cnt++; done_at = c; end
         step();
      end
      check("s_busy_cycles", busy_cnt, 8);
      check("s_done_count", done_cnt, 1);
      check("s_done_cycle", done_at, 9);
      for (int i = 0; i < 8; i++) begin
         s_raddr0 = 3'(i);
         #1;
         check("s_cleared", s_rdata0, 16'h0);
      end

      // Write 0xDEAD0000+i to each address; address 0 stays zero.
      for (int i = 0; i < NREG; i++) begin
         we = 1'b1; waddr = AW'(i);
         wdata = (i == 0) ? 32'hFFFFFFFF : 32'hDEAD0000 + i;
         step();
      end
      we = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         raddr0 = AW'(i); raddr1 = AW'(i);
         #1;
         check("readback0", rdata0, (i == 0) ? 32'h0 : 32'hDEAD0000 + i);
         check("readback1", rdata1, (i == 0) ? 32'h0 : 32'hDEAD0000 + i);
      end

      // Same-cycle bypass on both ports.
      we = 1'b1; waddr = 5'd7; wdata = 32'hCAFEF00D; raddr0 = 5'd7; raddr1 = 5'd7;
      #1;
      check("bypass0", rdata0, 32'hCAFEF00D);
      check("bypass1", rdata1, 32'hCAFEF00D);
      step();
      we = 1'b0;

      // Full clear: busy exactly NREG cycles, one done pulse after; writes while busy lost.
      for (int i = 0; i < NREG; i++) begin
         we = 1'b1; waddr = AW'(i); wdata = $urandom;
         step();
      end
      we = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0; done_at = 0;
      for (int c = 1; c <= 40; c++) begin
         if (clr_busy) busy_cnt++;
         if (clr_done) begin
            done_cnt++; done_at = c; we = 1'b0;
         end else if (clr_busy) begin
            we = 1'b1; waddr = AW'($urandom); wdata = $urandom;
         end
         clr_req = (c == 10) || clr_done;
         step();
      end
      clr_req = 1'b0; we = 1'b0;
      check("busy_cycles", busy_cnt, NREG);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_at, NREG + 1);
      for (int i = 0; i < NREG; i++) begin
         raddr0 = AW'(i); raddr1 = AW'(NREG - 1 - i);
         #1;
         check("cleared0", rdata0, 32'h0);
         check("cleared1", rdata1, 32'h0);
      end

      // Reset in the middle of a sweep aborts it with no done pulse.
      for (int i = 0; i < NREG; i++) begin
         we = 1'b1; waddr = AW'(i); wdata = 32'h1234_0000 | i;
         step();
      end
      we = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int c = 1; c < 10; c++) step();
      check("mid_busy", clr_busy, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("abort_busy", clr_busy, 1'b0);
      check("abort_done", clr_done, 1'b0);
      for (int i = 0; i < NREG; i++) begin
         raddr0 = AW'(i);
         #1;
         check("abort_zero", rdata0, 32'h0);
      end
      step();
      step();
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         if (clr_done) done_cnt++;
         step();
      end
      check("abort_no_done", done_cnt, 0);
      for (int i = 1; i < NREG; i += 5) begin
         raddr1 = AW'(i);
         #1;
         check("post_abort_zero", rdata1, 32'h0);
      end
      we = 1'b1; waddr = 5'd9; wdata = 32'h5555AAAA;
      step();
      we = 1'b0; clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         if (clr_busy) busy_cnt++;
         if (clr_done) done_cnt++;
         step();
      end
      check("resweep_busy", busy_cnt, NREG);
      check("resweep_done", done_cnt, 1);

      // Random traffic with occasional clears, all checked by the model.
      for (int c = 0; c < 600; c++) begin
         we      = 1'($urandom_range(0, 1));
         waddr   = AW'($urandom);
         wdata   = $urandom;
         raddr0  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
         raddr1  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
         clr_req = ($urandom_range(0, 59) == 0);
         step();
      end
      we = 1'b0; clr_req = 1'b0;
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
